// File: rtl/locker_door_controller.sv
// Locker bank door controller: owns occupancy, allocates the lowest free locker on an
// authenticated deposit, releases on an authenticated retrieval, and times each door-open window.
module locker_door_controller #(
    parameter int NUM_LOCKERS = 8,
    parameter int IDX_W       = 3,
    parameter int OPEN_CYCLES = 16,
    parameter int TIMER_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reset_lockers,
    input  logic                   deposit_req,
    input  logic                   auth_success,
    input  logic                   package_present,
    input  logic                   retrieval_req,
    input  logic                   retrieval_auth,
    input  logic [IDX_W-1:0]       retrieval_locker,
    output logic [NUM_LOCKERS-1:0] locker_doors,
    output logic [IDX_W-1:0]       assigned_locker_display,
    output logic [NUM_LOCKERS-1:0] occupied,
    output logic                   lockers_full,
    output logic                   busy,
    output logic                   req_error
);

    typedef enum logic [1:0] {
        IDLE,
        DEP_OPEN,
        RET_OPEN
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(OPEN_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [NUM_LOCKERS-1:0] doors_q, doors_d;
    logic [IDX_W-1:0]       display_q, display_d;
    logic [NUM_LOCKERS-1:0] occupied_q, occupied_d;
    logic                   reqErr_q, reqErr_d;

    logic [IDX_W-1:0]       freeIdx;
    logic                   bankFull;
    logic                   depAccept;
    logic                   retAccept;

    // Scan downward so the lowest-numbered clear bit is the one left standing.
    always_comb begin
        freeIdx = '0;
        for (int i = NUM_LOCKERS - 1; i >= 0; i--) begin
            if (!occupied_q[i]) begin
                freeIdx = IDX_W'(i);
            end
        end
    end

    assign bankFull  = &occupied_q;
    assign depAccept = (state_q == IDLE) && deposit_req && auth_success
                       && package_present && !bankFull;
    assign retAccept = (state_q == IDLE) && retrieval_req && retrieval_auth
                       && occupied_q[retrieval_locker] && !depAccept;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        doors_d    = doors_q;
        display_d  = display_q;
        occupied_d = occupied_q;
        reqErr_d   = (deposit_req && !depAccept) || (retrieval_req && !retAccept);

        if (reset_lockers) begin
            state_d    = IDLE;
            timer_d    = '0;
            doors_d    = '0;
            occupied_d = '0;
            reqErr_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (depAccept) begin
                        occupied_d[freeIdx] = 1'b1;
                        doors_d             = NUM_LOCKERS'(1) << freeIdx;
                        display_d           = freeIdx;
                        timer_d             = TIMER_LOAD;
                        state_d             = DEP_OPEN;
                    end else if (retAccept) begin
                        doors_d   = NUM_LOCKERS'(1) << retrieval_locker;
                        display_d = retrieval_locker;
                        timer_d   = TIMER_LOAD;
                        state_d   = RET_OPEN;
                    end
                end
                DEP_OPEN, RET_OPEN: begin
                    if (timer_q == '0) begin
                        doors_d = '0;
                        state_d = IDLE;
                        // The display register still names the retrieved locker here.
                        if (state_q == RET_OPEN) begin
                            occupied_d[display_q] = 1'b0;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    doors_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            doors_q    <= '0;
            display_q  <= '0;
            occupied_q <= '0;
            reqErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            doors_q    <= doors_d;
            display_q  <= display_d;
            occupied_q <= occupied_d;
            reqErr_q   <= reqErr_d;
        end
    end

    assign locker_doors            = doors_q;
    assign assigned_locker_display = display_q;
    assign occupied                = occupied_q;
    assign lockers_full            = bankFull;
    assign busy                    = (state_q != IDLE);
    assign req_error               = reqErr_q;

endmodule

// File: tb/tb_locker_door_controller.sv
// Directed bench for locker_door_controller: hand-computed allocation, open-window timing,
// rejection pulses, reset_lockers and asynchronous reset.
module tb_locker_door_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_lockers;
    logic       deposit_req;
    logic       auth_success;
    logic       package_present;
    logic       retrieval_req;
    logic       retrieval_auth;
    logic [2:0] retrieval_locker;
    logic [7:0] locker_doors;
    logic [2:0] assigned_locker_display;
    logic [7:0] occupied;
    logic       lockers_full;
    logic       busy;
    logic       req_error;

    int assertCount = 0;
    int failCount   = 0;

    locker_door_controller #(
        .NUM_LOCKERS(8),
        .IDX_W(3),
        .OPEN_CYCLES(16),
        .TIMER_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .reset_lockers(reset_lockers),
        .deposit_req(deposit_req),
        .auth_success(auth_success),
        .package_present(package_present),
        .retrieval_req(retrieval_req),
        .retrieval_auth(retrieval_auth),
        .retrieval_locker(retrieval_locker),
        .locker_doors(locker_doors),
        .assigned_locker_display(assigned_locker_display),
        .occupied(occupied),
        .lockers_full(lockers_full),
        .busy(busy),
        .req_error(req_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Holds the given request inputs for exactly one clock edge, then returns them to idle.
    task automatic applyStimulus(input logic dep, input logic auth, input logic pkg,
                                 input logic ret, input logic rauth, input logic [2:0] rloc);
        deposit_req      = dep;
        auth_success     = auth;
        package_present  = pkg;
        retrieval_req    = ret;
        retrieval_auth   = rauth;
        retrieval_locker = rloc;
        tick();
        deposit_req      = 1'b0;
        auth_success     = 1'b0;
        package_present  = 1'b0;
        retrieval_req    = 1'b0;
        retrieval_auth   = 1'b0;
        retrieval_locker = 3'd0;
    endtask

    task automatic waitClose(input string tag, input logic [7:0] doorsExp);
        repeat (15) tick();
        checkOutput({tag, "_doors_last"}, 32'(locker_doors), 32'(doorsExp));
        tick();
        checkOutput({tag, "_doors_closed"}, 32'(locker_doors), 32'h0);
        checkOutput({tag, "_busy_closed"}, 32'(busy), 32'h0);
    endtask

    task automatic depositAndClose(input string tag, input logic [2:0] idxExp,
                                   input logic [7:0] occExp);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput({tag, "_display"}, 32'(assigned_locker_display), 32'(idxExp));
        checkOutput({tag, "_doors"}, 32'(locker_doors), 32'(8'd1 << idxExp));
        checkOutput({tag, "_occ"}, 32'(occupied), 32'(occExp));
        waitClose(tag, 8'd1 << idxExp);
    endtask

    initial begin
        reset            = 1'b1;
        reset_lockers    = 1'b0;
        deposit_req      = 1'b0;
        auth_success     = 1'b0;
        package_present  = 1'b0;
        retrieval_req    = 1'b0;
        retrieval_auth   = 1'b0;
        retrieval_locker = 3'd0;
        #12;
        checkOutput("rst_doors", 32'(locker_doors), 32'h0);
        checkOutput("rst_occ", 32'(occupied), 32'h0);
        checkOutput("rst_display", 32'(assigned_locker_display), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_err", 32'(req_error), 32'h0);
        reset = 1'b0;
        tick();

        // Test 1: first deposit, door held for 16 cycles
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput("t1_doors", 32'(locker_doors), 32'h01);
        checkOutput("t1_occ", 32'(occupied), 32'h01);
        checkOutput("t1_display", 32'(assigned_locker_display), 32'h0);
        checkOutput("t1_busy", 32'(busy), 32'h1);
        waitClose("t1", 8'h01);

        // Test 2: fill the bank in order, then a rejected 9th deposit
        depositAndClose("t2_l1", 3'd1, 8'h03);
        depositAndClose("t2_l2", 3'd2, 8'h07);
        depositAndClose("t2_l3", 3'd3, 8'h0F);
        depositAndClose("t2_l4", 3'd4, 8'h1F);
        depositAndClose("t2_l5", 3'd5, 8'h3F);
        depositAndClose("t2_l6", 3'd6, 8'h7F);
        depositAndClose("t2_l7", 3'd7, 8'hFF);
        checkOutput("t2_full", 32'(lockers_full), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput("t2_full_err", 32'(req_error), 32'h1);
        checkOutput("t2_full_doors", 32'(locker_doors), 32'h0);
        checkOutput("t2_full_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("t2_err_pulse", 32'(req_error), 32'h0);

        // Test 3: build occupied=00000101, retrieve locker 2, redeposit
        reset_lockers = 1'b1;
        tick();
        reset_lockers = 1'b0;
        checkOutput("t3_clear_occ", 32'(occupied), 32'h0);
        depositAndClose("t3_d0", 3'd0, 8'h01);
        depositAndClose("t3_d1", 3'd1, 8'h03);
        depositAndClose("t3_d2", 3'd2, 8'h07);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
        checkOutput("t3_r1_doors", 32'(locker_doors), 32'h02);
        waitClose("t3_r1", 8'h02);
        checkOutput("t3_r1_occ", 32'(occupied), 32'h05);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
        checkOutput("t3_r2_doors", 32'(locker_doors), 32'h04);
        checkOutput("t3_r2_display", 32'(assigned_locker_display), 32'h2);
        checkOutput("t3_r2_occ_open", 32'(occupied), 32'h05);
        checkOutput("t3_r2_busy", 32'(busy), 32'h1);
        waitClose("t3_r2", 8'h04);
        checkOutput("t3_r2_occ", 32'(occupied), 32'h01);
        checkOutput("t3_display_hold", 32'(assigned_locker_display), 32'h2);
        depositAndClose("t3_redep", 3'd1, 8'h03);

        // Test 4: rejected requests leave state alone
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput("t4_noauth_err", 32'(req_error), 32'h1);
        checkOutput("t4_noauth_doors", 32'(locker_doors), 32'h0);
        checkOutput("t4_noauth_occ", 32'(occupied), 32'h03);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("t4_nopkg_err", 32'(req_error), 32'h1);
        checkOutput("t4_nopkg_occ", 32'(occupied), 32'h03);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
        checkOutput("t4_empty_err", 32'(req_error), 32'h1);
        checkOutput("t4_empty_doors", 32'(locker_doors), 32'h0);
        checkOutput("t4_empty_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("t4_err_clear", 32'(req_error), 32'h0);
        checkOutput("t4_display", 32'(assigned_locker_display), 32'h1);

        // Test 5: deposit beats a simultaneous valid retrieval; request while open
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        checkOutput("t5_doors", 32'(locker_doors), 32'h04);
        checkOutput("t5_display", 32'(assigned_locker_display), 32'h2);
        checkOutput("t5_err", 32'(req_error), 32'h1);
        checkOutput("t5_occ", 32'(occupied), 32'h07);
        repeat (4) tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput("t5_busy_err", 32'(req_error), 32'h1);
        checkOutput("t5_busy_doors", 32'(locker_doors), 32'h04);
        checkOutput("t5_busy_occ", 32'(occupied), 32'h07);
        repeat (10) tick();
        checkOutput("t5_doors_last", 32'(locker_doors), 32'h04);
        tick();
        checkOutput("t5_doors_closed", 32'(locker_doors), 32'h0);
        checkOutput("t5_occ_after", 32'(occupied), 32'h07);

        // Test 6: reset_lockers mid-window, then asynchronous reset mid-window
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput("t6_doors", 32'(locker_doors), 32'h08);
        repeat (3) tick();
        reset_lockers = 1'b1;
        deposit_req   = 1'b1;
        tick();
        reset_lockers = 1'b0;
        deposit_req   = 1'b0;
        checkOutput("t6_rl_doors", 32'(locker_doors), 32'h0);
        checkOutput("t6_rl_occ", 32'(occupied), 32'h0);
        checkOutput("t6_rl_busy", 32'(busy), 32'h0);
        checkOutput("t6_rl_err", 32'(req_error), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput("t6_d_doors", 32'(locker_doors), 32'h01);
        repeat (3) tick();
        #1 reset = 1'b1;
        #1;
        checkOutput("t6_ar_doors", 32'(locker_doors), 32'h0);
        checkOutput("t6_ar_occ", 32'(occupied), 32'h0);
        checkOutput("t6_ar_busy", 32'(busy), 32'h0);
        checkOutput("t6_ar_display", 32'(assigned_locker_display), 32'h0);
        #1 reset = 1'b0;
        tick();
        checkOutput("t6_after_doors", 32'(locker_doors), 32'h0);
        checkOutput("t6_after_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/locker_door_controller.md
Name: locker_door_controller

Overview:
Downstream stage of the delivery locker authentication front end. It consumes the deposit-auth, retrieval-auth and package-present indications. It owns the occupancy register for the locker bank, allocates the lowest free locker on an authenticated deposit, and releases it on an authenticated retrieval. It drives the one-hot door-unlock outputs for a fixed open window, then relocks.

Parameters:
NUM_LOCKERS, 8, number of lockers; power of two, 2..16
IDX_W, 3, locker index width = log2(NUM_LOCKERS)
OPEN_CYCLES, 16, clock cycles a door stays unlocked; 1..2^TIMER_W-1
TIMER_W, 8, width of the door-open down-counter

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
reset_lockers  in  1  synchronous clear of all occupancy; aborts any open door
deposit_req  in  1  one-cycle deposit request strobe
auth_success  in  1  deposit PIN match; sampled with deposit_req
package_present  in  1  package sensed at the counter; sampled with deposit_req
retrieval_req  in  1  one-cycle retrieval request strobe
retrieval_auth  in  1  retrieval PIN match; sampled with retrieval_req
retrieval_locker  in  IDX_W  locker index to retrieve from
locker_doors  out  NUM_LOCKERS  one-hot unlock drive, registered
assigned_locker_display  out  IDX_W  index of the last locker opened, registered
occupied  out  NUM_LOCKERS  occupancy register
lockers_full  out  1  all occupied bits set (combinational from occupied)
busy  out  1  high when the FSM is not in IDLE
req_error  out  1  one-cycle pulse on any rejected request

Behaviour:
- Reset (async assert, any time): state=IDLE; locker_doors=0; assigned_locker_display=0; occupied=0; timer=0; req_error=0; busy=0. Reset asserted mid-open closes the door immediately and drops that transaction. Occupancy is not updated for it.
- FSM states: IDLE, DEP_OPEN, RET_OPEN.
- IDLE, edge k, accept deposit when deposit_req & auth_success & package_present & !lockers_full:
  - idx = lowest-numbered clear bit of occupied.
  - occupied[idx] set at edge k.
  - locker_doors = one-hot(idx) and assigned_locker_display = idx from edge k.
  - timer = OPEN_CYCLES-1; state = DEP_OPEN.
- IDLE, edge k, accept retrieval when retrieval_req & retrieval_auth & occupied[retrieval_locker], and no deposit is accepted in the same cycle:
  - locker_doors = one-hot(retrieval_locker); assigned_locker_display = retrieval_locker.
  - timer = OPEN_CYCLES-1; state = RET_OPEN.
  - occupied bit cleared when the door closes.
- Simultaneous deposit and retrieval requests, both valid: deposit wins. The retrieval is rejected (req_error pulses).
- Rejections: any deposit_req or retrieval_req not accepted in IDLE pulses req_error for 1 cycle at k+1. This covers failed auth, no package, bank full, unoccupied locker, and a request while busy. State and outputs are otherwise unchanged.
- DEP_OPEN/RET_OPEN:
  - Each cycle, timer decrements.
  - At the edge where timer==0: locker_doors=0 and state=IDLE. In RET_OPEN, occupied[idx] also clears at this edge.
  - Door is high for exactly OPEN_CYCLES cycles.
  - A new request is accepted at the earliest one cycle after the door drops.
- reset_lockers (synchronous, highest priority after reset): occupied=0, locker_doors=0, timer=0, state=IDLE at the next edge. Any request in the same cycle is ignored with no req_error.
- assigned_locker_display holds its value after the door closes until the next accepted transaction.
- retrieval_locker is sampled only on acceptance; values >= NUM_LOCKERS cannot occur because the width is exact.
- lockers_full = &occupied. busy = (state != IDLE).

Test Plan:
1. Reset, then deposit_req+auth_success+package_present at edge 1 -> locker_doors=8'b00000001 for 16 cycles, occupied=8'b00000001, display=0, then doors=0, busy=0.
2. Eight accepted deposits in sequence -> lockers allocated 0..7 in order, occupied=8'hFF, lockers_full=1. A 9th deposit -> req_error pulse, doors stay 0.
3. With occupied=8'b00000101, retrieval of locker 2 with retrieval_auth=1 -> doors=8'b00000100 for 16 cycles, then occupied=8'b00000001. Next deposit gets locker 1.
4. Deposit with auth_success=0, deposit with package_present=0, and retrieval of empty locker 3 -> req_error pulse each time; occupied and doors unchanged.
5. Deposit and valid retrieval in the same cycle -> deposit served, req_error=1. A deposit_req while in DEP_OPEN -> req_error, timer unaffected.
6. reset_lockers asserted at cycle 5 of an open window -> doors=0, occupied=0, IDLE next edge. Async reset pulse mid-window -> all outputs 0 without waiting for a clock edge.
